// File: rtl/serial_pll_sup_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the PLL supervisor.
// Latency: none (declarations only).
// Backpressure: none.
package serial_pll_sup_pkg;

  // Encoding is visible on the state port, so the values are fixed.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    RETRY     = 3'd4,
    FAILED    = 3'd5
  } sup_state_e;

  localparam int RST_CYCLES_DEF          = 16;
  localparam int LOCK_TIMEOUT_CYCLES_DEF = 125000;  // 1 ms at 125 MHz
  localparam int LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int MAX_RETRIES_DEF         = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of the shared cycle counter: enough to hold the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_pll_supervisor_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from input change to q.
// Backpressure: none; level signal, no handshake.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both flops clear to 0 so "not locked" is assumed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_pll_supervisor.sv
// serial_pll_supervisor: sequences PLL reset, lock wait, lock qualification and retries; gates the UART reset.
// Latency: pll_locked fall in RUN -> uart_rst_n low after 3 refclk edges; outputs registered from next state.
// Backpressure: none; restart is a single-cycle request that wins over every transition. Macro: SERIAL_PLL_LOSS_CNT_EN adds loss_cnt.
module serial_pll_supervisor
  import serial_pll_sup_pkg::*;
#(
  parameter int RST_CYCLES          = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int MAX_RETRIES         = MAX_RETRIES_DEF
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       uart_rst_n,
  output logic       ready,
  output logic       failed,
  output logic [2:0] state,
  output logic [1:0] retries
`ifdef SERIAL_PLL_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  // The counter is cleared to 0 on every state entry and decremented each
  // cycle, so the number of cycles already spent in the state is -cnt_q.
  // Terminal checks compare that elapsed count against "length - 1".
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees locked_s already counts as one
  // stable cycle, so STABLE itself needs one cycle fewer.
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam bit STB_DIRECT = (LOCK_STABLE_CYCLES <= 1);

  logic             locked_s;
  sup_state_e       cur_st;
  sup_state_e       nxt_st;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] elapsed;
  logic [1:0]       retries_q;
  logic [1:0]       retries_nxt;
  logic             pll_rst_nxt;
  logic             run_nxt;
  logic             failed_nxt;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign elapsed = -cnt_q;
  assign state   = cur_st;
  assign retries = retries_q;

  // State, counter, retry count and registered outputs all update on the same edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st     <= PLL_RST;
      cnt_q      <= '0;
      retries_q  <= 2'd0;
      pll_rst    <= 1'b1;
      uart_rst_n <= 1'b0;
      ready      <= 1'b0;
      failed     <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
      cnt_q      <= cnt_nxt;
      retries_q  <= retries_nxt;
      pll_rst    <= pll_rst_nxt;
      uart_rst_n <= run_nxt;
      ready      <= run_nxt;
      failed     <= failed_nxt;
    end
  end

  // Next-state, counter and retry decisions; restart overrides everything.
  always_comb begin
    nxt_st      = cur_st;
    cnt_nxt     = cnt_q - CNT_ONE;
    retries_nxt = retries_q;
    if (restart) begin
      nxt_st      = PLL_RST;
      cnt_nxt     = '0;
      retries_nxt = 2'd0;
    end else begin
      case (cur_st)
        PLL_RST: begin
          if (elapsed == RST_LAST) begin
            nxt_st  = WAIT_LOCK;
            cnt_nxt = '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            nxt_st  = STB_DIRECT ? RUN : STABLE;
            cnt_nxt = '0;
          end else if (elapsed == TMO_LAST) begin
            nxt_st  = RETRY;
            cnt_nxt = '0;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            // Any dropout restarts qualification and the lock timeout.
            nxt_st  = WAIT_LOCK;
            cnt_nxt = '0;
          end else if (elapsed == STB_LAST) begin
            nxt_st  = RUN;
            cnt_nxt = '0;
          end
        end
        RUN: begin
          cnt_nxt = '0;
          if (!locked_s) nxt_st = RETRY;
        end
        RETRY: begin
          cnt_nxt = '0;
          if (int'(retries_q) >= MAX_RETRIES) begin
            nxt_st = FAILED;
          end else begin
            nxt_st = PLL_RST;
            if (retries_q != 2'd3) retries_nxt = retries_q + 2'd1;
          end
        end
        FAILED: begin
          cnt_nxt = '0;
        end
        default: begin
          nxt_st  = PLL_RST;
          cnt_nxt = '0;
        end
      endcase
    end
    // A good clock wipes the retry history, including on the entry edge.
    if (nxt_st == RUN) retries_nxt = 2'd0;
  end

  // Output values decoded from the next state so the registers track the state register.
  always_comb begin
    pll_rst_nxt = (nxt_st == PLL_RST) || (nxt_st == FAILED);
    run_nxt     = (nxt_st == RUN);
    failed_nxt  = (nxt_st == FAILED);
  end

`ifdef SERIAL_PLL_LOSS_CNT_EN
  // Count lock losses out of RUN; saturates and only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if ((cur_st == RUN) && (nxt_st == RETRY) && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/serial_pll_supervisor.md
SERIAL_PLL_SUPERVISOR -- requirements
Module: serial_pll_supervisor

Interface
- REQ-001 Parameters SHALL be:
  - RST_CYCLES, default 16: PLL reset pulse length in refclk cycles.
  - LOCK_TIMEOUT_CYCLES, default 125000: maximum wait for lock (1 ms at 125 MHz).
  - LOCK_STABLE_CYCLES, default 1024: cycles lock must hold continuously before release.
  - MAX_RETRIES, default 3: PLL restarts allowed before FAILED.
- REQ-002 Ports SHALL be:
  - refclk, in, 1: the single clock, free-running 125 MHz.
  - rst_n, in, 1: asynchronous active-low reset.
  - pll_locked, in, 1: PLL lock, asynchronous to refclk.
  - restart, in, 1: synchronous single-cycle restart request.
  - pll_rst, out, 1: active-high PLL reset.
  - uart_rst_n, out, 1: active-low reset for the 1.8432 MHz UART domain.
  - ready, out, 1: clock is good.
  - failed, out, 1: sticky failure.
  - state, out, 3: current FSM state.
  - retries, out, 2: retries used.
  - loss_cnt, out, 8: lock-loss count; present only with the macro.
- REQ-003 There SHALL be one clock (refclk), and reset SHALL be asynchronous active-low (rst_n).

Function
- REQ-004 pll_locked SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value locked_s.
- REQ-005 State encoding SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, RETRY=4, FAILED=5.
- REQ-006 PLL_RST SHALL drive pll_rst=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with the cycle counter cleared.
- REQ-007 WAIT_LOCK SHALL drive pll_rst=0 and transition as follows:
  - locked_s=1 -> STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 without lock -> RETRY.
- REQ-008 STABLE SHALL transition as follows:
  - locked_s=0 on any cycle -> WAIT_LOCK, counter cleared, which restarts the timeout.
  - LOCK_STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN.
- REQ-009 RUN SHALL assert ready=1 and uart_rst_n=1 and clear retries.
- REQ-010 In RUN, locked_s=0 SHALL cause RETRY on the next edge.
- REQ-011 RETRY SHALL last one cycle:
  - retries==MAX_RETRIES -> FAILED.
  - Otherwise retries increments (saturating) -> PLL_RST.
- REQ-012 FAILED SHALL hold pll_rst=1, failed=1, ready=0 and uart_rst_n=0 until restart.
- REQ-013 restart=1 SHALL take priority over every other transition: next state PLL_RST, retries=0, failed=0.
- REQ-014 Outputs SHALL be registered from next-state so they change on the same edge as the state register, with no combinational glitches.
- REQ-015 Per-state outputs SHALL be:
  - pll_rst=1 only in PLL_RST and FAILED.
  - uart_rst_n=1 and ready=1 only in RUN.
  - uart_rst_n SHALL fall on the edge that leaves RUN.
- REQ-016 Worst-case delay from a pll_locked fall in RUN to uart_rst_n=0 SHALL be 3 refclk cycles.

Reset
- REQ-017 While rst_n=0 the block SHALL hold state=PLL_RST, pll_rst=1, uart_rst_n=0, ready=0, failed=0, retries=0, loss_cnt=0, counter=0, and synchronizer flops=0.
- REQ-018 Asserting rst_n in any state, including mid-RUN, SHALL force the REQ-017 values immediately, without waiting for a clock edge.
- REQ-019 After rst_n deasserts, the full RST_CYCLES PLL reset pulse SHALL restart from count 0.

Configuration
- REQ-020 With SERIAL_PLL_LOSS_CNT_EN defined, loss_cnt SHALL exist:
  - Increments on each RUN->RETRY transition.
  - Saturates at 255.
  - Clears only on rst_n.
- REQ-021 Without SERIAL_PLL_LOSS_CNT_EN, the loss_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
- REQ-022 Package serial_pll_sup_pkg SHALL hold the state enum and the default parameter constants.
- REQ-023 The synchronizer SHALL be sub-module sync_2ff with reset value 0.
- REQ-024 The counter SHALL be one shared down-counter sized for the maximum of the three cycle parameters.

Verification
- REQ-025 The bench SHALL use RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- REQ-026 Lock good: pll_locked rises 10 cycles after rst_n deasserts and stays high -> pll_rst high for 4 cycles; ready=uart_rst_n=1 exactly 2+8 cycles after pll_locked rises.
- REQ-027 Never lock: pll_locked held 0 -> two retries each of 4+32+1 cycles, then a third timeout -> failed=1, pll_rst=1, retries=2, state=5.
- REQ-028 Stability glitch: pll_locked low for 1 cycle at STABLE count 5 -> back to WAIT_LOCK; RUN entered 8 cycles after locked_s returns high.
- REQ-029 Loss in RUN: pll_locked falls -> uart_rst_n=0 within 3 cycles, state passes through RETRY to PLL_RST; loss_cnt=1 when the macro is defined.
- REQ-030 Restart: restart pulse while in FAILED -> next cycle state=0, failed=0, retries=0, and a normal lock sequence follows.
- REQ-031 Reset mid-RUN: rst_n driven low -> all outputs reach REQ-017 values before the next refclk edge.
